// File: rtl/ccff_prog_seq.sv
// Configuration-chain programming sequencer: pulses pReset, streams CHAIN_LEN
// bitstream bits MSB-first onto the ccff head, then releases the fabric.
module ccff_prog_seq #(
   parameter int DATA_W     = 32,
   parameter int CHAIN_LEN  = 1024,
   parameter int CNT_W      = 16,
   parameter int HALF       = 2,
   parameter int PRESET_CYC = 8,
   parameter int TIMEOUT    = 4096
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [DATA_W-1:0] word_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   output logic              data_o,
   output logic              progclk_o,
   output logic              pReset_o,
   output logic              fpga_rst_o,
   output logic              fpga_clk_en_o,
   input  logic              ccff_tail_i,
   output logic              tail_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
);

   localparam int PH_W   = $clog2(2*HALF + 1);
   localparam int PRE_W  = $clog2(PRESET_CYC + 1);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int WB_W   = $clog2(DATA_W + 1);

   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2*HALF - 1);
   localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(HALF);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESET_CYC - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [WB_W-1:0]   WB_LAST   = WB_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESET,
      S_LOAD,
      S_SHIFT,
      S_FINISH,
      S_DONE,
      S_ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [PH_W-1:0]     ph_q, ph_d, ph_inc;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [WB_W-1:0]     wbit_q, wbit_d;
   logic [CNT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d, shifted;

   logic data_d, progclk_d, preset_d, fpga_rst_d, clk_en_d;
   logic ready_d, tail_d, busy_d, done_d, error_d;

   // State, counters and every output are registered from the *_d values below.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         ph_q          <= '0;
         pre_q         <= '0;
         wait_q        <= '0;
         wbit_q        <= '0;
         bit_q         <= '0;
         shreg_q       <= '0;
         data_o        <= 1'b0;
         progclk_o     <= 1'b0;
         pReset_o      <= 1'b0;
         fpga_rst_o    <= 1'b1;
         fpga_clk_en_o <= 1'b0;
         word_ready_o  <= 1'b0;
         tail_o        <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         error_o       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ph_q          <= ph_d;
         pre_q         <= pre_d;
         wait_q        <= wait_d;
         wbit_q        <= wbit_d;
         bit_q         <= bit_d;
         shreg_q       <= shreg_d;
         data_o        <= data_d;
         progclk_o     <= progclk_d;
         pReset_o      <= preset_d;
         fpga_rst_o    <= fpga_rst_d;
         fpga_clk_en_o <= clk_en_d;
         word_ready_o  <= ready_d;
         tail_o        <= tail_d;
         busy_o        <= busy_d;
         done_o        <= done_d;
         error_o       <= error_d;
      end
   end

   // Next-state and next-output logic; abort overrides everything including start.
   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      pre_d      = pre_q;
      wait_d     = wait_q;
      wbit_d     = wbit_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      data_d     = data_o;
      progclk_d  = progclk_o;
      preset_d   = pReset_o;
      fpga_rst_d = fpga_rst_o;
      clk_en_d   = fpga_clk_en_o;
      ready_d    = word_ready_o;
      tail_d     = tail_o;
      busy_d     = busy_o;
      done_d     = done_o;
      error_d    = error_o;
      shifted    = shreg_q << 1;
      ph_inc     = ph_q + PH_W'(1);

      if (abort_i) begin
         state_d    = S_IDLE;
         ph_d       = '0;
         pre_d      = '0;
         wait_d     = '0;
         wbit_d     = '0;
         bit_d      = '0;
         shreg_d    = '0;
         data_d     = 1'b0;
         progclk_d  = 1'b0;
         preset_d   = 1'b0;
         fpga_rst_d = 1'b1;
         clk_en_d   = 1'b0;
         ready_d    = 1'b0;
         tail_d     = 1'b0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         error_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_i) begin
                  state_d    = S_PRESET;
                  ph_d       = '0;
                  pre_d      = '0;
                  wait_d     = '0;
                  wbit_d     = '0;
                  bit_d      = '0;
                  shreg_d    = '0;
                  data_d     = 1'b0;
                  progclk_d  = 1'b0;
                  preset_d   = 1'b1;
                  fpga_rst_d = 1'b1;
                  clk_en_d   = 1'b0;
                  ready_d    = 1'b0;
                  busy_d     = 1'b1;
                  done_d     = 1'b0;
                  error_d    = 1'b0;
               end
            end

            S_PRESET: begin
               if (pre_q == PRE_LAST) begin
                  state_d  = S_LOAD;
                  pre_d    = '0;
                  wait_d   = '0;
                  preset_d = 1'b0;
                  ready_d  = 1'b1;
               end else begin
                  pre_d = pre_q + PRE_W'(1);
               end
            end

            // The first bit is placed on data_o in the same edge that accepts the word.
            S_LOAD: begin
               if (word_valid_i && word_ready_o) begin
                  state_d   = S_SHIFT;
                  shreg_d   = word_i;
                  data_d    = word_i[DATA_W-1];
                  progclk_d = 1'b0;
                  ready_d   = 1'b0;
                  ph_d      = '0;
                  wbit_d    = '0;
                  wait_d    = '0;
               end else if (wait_q == WAIT_LAST) begin
                  state_d   = S_ERROR;
                  wait_d    = '0;
                  ready_d   = 1'b0;
                  progclk_d = 1'b0;
                  error_d   = 1'b1;
                  busy_d    = 1'b0;
                  fpga_rst_d = 1'b1;
                  clk_en_d  = 1'b0;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end

            S_SHIFT: begin
               if (ph_q == PH_LAST) begin
                  shreg_d   = shifted;
                  bit_d     = bit_q + CNT_W'(1);
                  wbit_d    = wbit_q + WB_W'(1);
                  ph_d      = '0;
                  progclk_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d = S_FINISH;
                     data_d  = 1'b0;
                  end else if (wbit_q == WB_LAST) begin
                     state_d = S_LOAD;
                     wbit_d  = '0;
                     wait_d  = '0;
                     ready_d = 1'b1;
                  end else begin
                     data_d = shifted[DATA_W-1];
                  end
               end else begin
                  ph_d      = ph_inc;
                  progclk_d = (ph_inc >= PH_HIGH);
                  if (ph_inc == PH_HIGH) begin
                     tail_d = ccff_tail_i;
                  end
               end
            end

            // One idle progclk period before the fabric is let go.
            S_FINISH: begin
               progclk_d = 1'b0;
               data_d    = 1'b0;
               if (ph_q == PH_LAST) begin
                  state_d    = S_DONE;
                  ph_d       = '0;
                  fpga_rst_d = 1'b0;
                  clk_en_d   = 1'b1;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
               end else begin
                  ph_d = ph_inc;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_prog_seq.sv
// Self-checking bench for ccff_prog_seq: directed scenarios plus random words and
// stalls, compared against a bit-stream model built from plain word arithmetic.
module tb_ccff_prog_seq;

   localparam int DW  = 32;
   localparam int CL  = 40;
   localparam int HF  = 2;
   localparam int PC  = 4;
   localparam int TO  = 16;
   localparam int NWORDS = (CL + DW - 1) / DW;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic          abort_i;
   logic [DW-1:0] word_i;
   logic          word_valid_i;
   logic          word_ready_o;
   logic          data_o;
   logic          progclk_o;
   logic          pReset_o;
   logic          fpga_rst_o;
   logic          fpga_clk_en_o;
   logic          ccff_tail_i;
   logic          tail_o;
   logic          busy_o;
   logic          done_o;
   logic          error_o;

   int compared   = 0;
   int mismatched = 0;

   int   rise_cnt   = 0;
   int   preset_cnt = 0;
   int   hs_cnt     = 0;
   logic prev_pc    = 1'b0;
   logic bit_q[$];
   logic tail_q[$];
   logic [CL-1:0] chain = '0;

   ccff_prog_seq #(
      .DATA_W(DW), .CHAIN_LEN(CL), .CNT_W(16), .HALF(HF),
      .PRESET_CYC(PC), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
      .data_o(data_o), .progclk_o(progclk_o), .pReset_o(pReset_o),
      .fpga_rst_o(fpga_rst_o), .fpga_clk_en_o(fpga_clk_en_o),
      .ccff_tail_i(ccff_tail_i), .tail_o(tail_o), .busy_o(busy_o),
      .done_o(done_o), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   // A CL-stage chain model clocked by progclk, looping data_o back to the tail.
   always @(posedge progclk_o) chain <= {chain[CL-2:0], data_o};
   assign ccff_tail_i = chain[CL-1];

   always @(negedge clk_i) begin
      if (progclk_o === 1'b1 && prev_pc !== 1'b1) begin
         rise_cnt++;
         bit_q.push_back(data_o);
         tail_q.push_back(tail_o);
      end
      prev_pc = progclk_o;
      if (pReset_o === 1'b1) preset_cnt++;
      if (word_valid_i === 1'b1 && word_ready_o === 1'b1) hs_cnt++;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CL-1:0] expStream(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
      logic [DW-1:0] words [NWORDS];
      logic [CL-1:0] s;
      words[0] = w0;
      words[1] = w1;
      for (int i = 0; i < CL; i++) s[CL-1-i] = words[i / DW][DW-1 - (i % DW)];
      return s;
   endfunction

   task automatic sendWord(input string tag, input logic [DW-1:0] w, input int stall);
      int n;
      n = 0;
      word_i = w;
      word_valid_i = (stall == 0);
      while (word_ready_o !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) begin
         checkOutput({tag, "_ready_timeout"}, 64'(word_ready_o), 64'd1);
         word_valid_i = 1'b0;
         return;
      end
      for (int s = 0; s < stall; s++) begin
         checkOutput({tag, "_stall_ready"}, 64'(word_ready_o), 64'd1);
         checkOutput({tag, "_stall_progclk"}, 64'(progclk_o), 64'd0);
         tick();
      end
      word_valid_i = 1'b1;
      tick();
      word_valid_i = 1'b0;
      word_i = DW'($urandom);
   endtask

   task automatic applyStimulus(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input int stall, input bit poke,
                                output logic [CL-1:0] got_bits, output logic [CL-1:0] got_tails);
      int bq, rb, pb, hb, n;
      bq = bit_q.size();
      rb = rise_cnt;
      pb = preset_cnt;
      hb = hs_cnt;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      checkOutput({tag, "_start_busy"}, 64'(busy_o), 64'd1);
      checkOutput({tag, "_start_done"}, 64'(done_o), 64'd0);
      checkOutput({tag, "_start_error"}, 64'(error_o), 64'd0);
      checkOutput({tag, "_start_preset"}, 64'(pReset_o), 64'd1);
      checkOutput({tag, "_start_fpga_rst"}, 64'(fpga_rst_o), 64'd1);
      checkOutput({tag, "_start_clk_en"}, 64'(fpga_clk_en_o), 64'd0);
      sendWord({tag, "_w0"}, w0, 0);
      if (poke) begin
         tick();
         tick();
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
      end
      sendWord({tag, "_w1"}, w1, stall);
      n = 0;
      while (done_o !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checkOutput({tag, "_done"}, 64'(done_o), 64'd1);
      checkOutput({tag, "_fpga_rst"}, 64'(fpga_rst_o), 64'd0);
      checkOutput({tag, "_clk_en"}, 64'(fpga_clk_en_o), 64'd1);
      checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
      checkOutput({tag, "_error"}, 64'(error_o), 64'd0);
      checkOutput({tag, "_progclk_idle"}, 64'(progclk_o), 64'd0);
      checkOutput({tag, "_data_idle"}, 64'(data_o), 64'd0);
      checkOutput({tag, "_ready_idle"}, 64'(word_ready_o), 64'd0);
      checkOutput({tag, "_rises"}, 64'(rise_cnt - rb), 64'(CL));
      checkOutput({tag, "_preset_cycles"}, 64'(preset_cnt - pb), 64'(PC));
      checkOutput({tag, "_handshakes"}, 64'(hs_cnt - hb), 64'(NWORDS));
      for (int i = 0; i < CL; i++) begin
         got_bits[CL-1-i]  = (bq + i < bit_q.size())  ? bit_q[bq + i]  : 1'bx;
         got_tails[CL-1-i] = (bq + i < tail_q.size()) ? tail_q[bq + i] : 1'bx;
      end
      checkOutput({tag, "_stream"}, 64'(got_bits), 64'(expStream(w0, w1)));
   endtask

   initial begin
      logic [CL-1:0] s1, t1, s2, t2, sx, tx;
      logic [DW-1:0] ra, rb;
      int n, loads, base;

      rst_ni = 1'b0;
      start_i = 1'b0;
      abort_i = 1'b0;
      word_i = '0;
      word_valid_i = 1'b0;
      repeat (3) tick();
      checkOutput("rst_data", 64'(data_o), 64'd0);
      checkOutput("rst_progclk", 64'(progclk_o), 64'd0);
      checkOutput("rst_preset", 64'(pReset_o), 64'd0);
      checkOutput("rst_fpga_rst", 64'(fpga_rst_o), 64'd1);
      checkOutput("rst_clk_en", 64'(fpga_clk_en_o), 64'd0);
      checkOutput("rst_ready", 64'(word_ready_o), 64'd0);
      checkOutput("rst_tail", 64'(tail_o), 64'd0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
      checkOutput("rst_done", 64'(done_o), 64'd0);
      checkOutput("rst_error", 64'(error_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      $display("[TB] basic program");
      applyStimulus("basic", 32'hA5A5_0001, 32'hFF00_0000, 0, 1'b0, s1, t1);
      checkOutput("basic_literal", 64'(s1), {24'd0, 32'hA5A5_0001, 8'hFF});

      $display("[TB] backpressure, restart from DONE, tail loopback");
      applyStimulus("stall", 32'hA5A5_0001, 32'hFF00_0000, 10, 1'b0, s2, t2);
      checkOutput("stall_same_stream", 64'(s2), 64'(s1));
      checkOutput("tail_loopback", 64'(t2), 64'(s1));

      $display("[TB] start ignored while shifting");
      ra = $urandom;
      rb = $urandom;
      applyStimulus("poke", ra, rb, 0, 1'b1, sx, tx);

      $display("[TB] start and abort together from DONE");
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      checkOutput("both_done", 64'(done_o), 64'd0);
      checkOutput("both_busy", 64'(busy_o), 64'd0);
      checkOutput("both_preset", 64'(pReset_o), 64'd0);
      checkOutput("both_fpga_rst", 64'(fpga_rst_o), 64'd1);
      checkOutput("both_clk_en", 64'(fpga_clk_en_o), 64'd0);
      repeat (3) tick();
      checkOutput("both_stays_idle", 64'(pReset_o), 64'd0);

      $display("[TB] underrun");
      base = rise_cnt;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      sendWord("underrun_w0", DW'($urandom), 0);
      n = 0;
      loads = 0;
      while (error_o !== 1'b1 && n < 400) begin
         if (word_ready_o === 1'b1) loads++;
         tick();
         n++;
      end
      checkOutput("underrun_error", 64'(error_o), 64'd1);
      checkOutput("underrun_load_cycles", 64'(loads), 64'(TO));
      checkOutput("underrun_rises", 64'(rise_cnt - base), 64'(DW));
      checkOutput("underrun_fpga_rst", 64'(fpga_rst_o), 64'd1);
      checkOutput("underrun_clk_en", 64'(fpga_clk_en_o), 64'd0);
      checkOutput("underrun_busy", 64'(busy_o), 64'd0);
      checkOutput("underrun_done", 64'(done_o), 64'd0);
      checkOutput("underrun_progclk", 64'(progclk_o), 64'd0);
      checkOutput("underrun_ready", 64'(word_ready_o), 64'd0);

      $display("[TB] restart from ERROR");
      ra = $urandom;
      rb = $urandom;
      applyStimulus("from_error", ra, rb, 0, 1'b0, sx, tx);

      $display("[TB] abort at 20th progclk rise");
      base = rise_cnt;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      sendWord("abort_w0", DW'($urandom), 0);
      n = 0;
      while ((rise_cnt - base) < 20 && n < 400) begin
         tick();
         n++;
      end
      checkOutput("abort_reached_20", 64'(rise_cnt - base), 64'd20);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      checkOutput("abort_busy", 64'(busy_o), 64'd0);
      checkOutput("abort_done", 64'(done_o), 64'd0);
      checkOutput("abort_error", 64'(error_o), 64'd0);
      checkOutput("abort_fpga_rst", 64'(fpga_rst_o), 64'd1);
      checkOutput("abort_clk_en", 64'(fpga_clk_en_o), 64'd0);
      checkOutput("abort_progclk", 64'(progclk_o), 64'd0);
      checkOutput("abort_preset", 64'(pReset_o), 64'd0);
      checkOutput("abort_ready", 64'(word_ready_o), 64'd0);
      base = rise_cnt;
      repeat (12) tick();
      checkOutput("abort_no_rises", 64'(rise_cnt - base), 64'd0);
      ra = $urandom;
      rb = $urandom;
      applyStimulus("after_abort", ra, rb, 0, 1'b0, sx, tx);

      $display("[TB] random programs");
      for (int k = 0; k < 4; k++) begin
         ra = $urandom;
         rb = $urandom;
         applyStimulus($sformatf("rand%0d", k), ra, rb, int'($urandom_range(0, 12)),
                       1'($urandom_range(0, 1)), sx, tx);
      end

      $display("[TB] asynchronous reset mid-shift");
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      sendWord("areset_w0", DW'($urandom), 0);
      repeat (10) tick();
      #2;
      rst_ni = 1'b0;
      #1;
      checkOutput("areset_busy", 64'(busy_o), 64'd0);
      checkOutput("areset_progclk", 64'(progclk_o), 64'd0);
      checkOutput("areset_data", 64'(data_o), 64'd0);
      checkOutput("areset_fpga_rst", 64'(fpga_rst_o), 64'd1);
      tick();
      rst_ni = 1'b1;
      tick();
      ra = $urandom;
      rb = $urandom;
      applyStimulus("after_areset", ra, rb, 3, 1'b0, sx, tx);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ccff_prog_seq.md
Name: ccff_prog_seq

Overview:
Configuration-chain programming sequencer for the 2x2 FPGA fabric. It accepts decrypted bitstream words over a valid/ready stream and pulses pReset. It then serialises exactly CHAIN_LEN bits MSB-first onto the ccff head with a divided programming clock, and finally releases fabric reset and enables the fabric clock. It sits between the AES decrypt output path and the fabric configuration pins inside the PMU.

Parameters:
DATA_W, 32, stream word width
CHAIN_LEN, 1024, configuration chain length in bits (>=1)
CNT_W, 16, bit-counter width; must hold CHAIN_LEN
HALF, 2, system cycles per progclk half-period (>=1)
PRESET_CYC, 8, cycles pReset is held high (>=1)
TIMEOUT, 4096, max cycles waiting for a word before underrun error

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle request to begin programming
abort_i  in  1  one-cycle abort, any state
word_i  in  DATA_W  bitstream word
word_valid_i  in  1  word_i valid
word_ready_o  out  1  sequencer can accept a word
data_o  out  1  serial data to ccff head
progclk_o  out  1  programming clock
pReset_o  out  1  chain programming reset, active high
fpga_rst_o  out  1  fabric reset, active high
fpga_clk_en_o  out  1  fabric clock enable
ccff_tail_i  in  1  chain tail; registered and exposed on tail_o
tail_o  out  1  ccff_tail_i sampled on each progclk rising edge
busy_o  out  1  high from accepted start until DONE/ERROR/IDLE
done_o  out  1  sticky, programming completed
error_o  out  1  sticky, word underrun timeout

Behaviour:
- Reset values: data_o=0, progclk_o=0, pReset_o=0, fpga_rst_o=1, fpga_clk_en_o=0, word_ready_o=0, tail_o=0, busy_o=0, done_o=0, error_o=0. State=IDLE, counters=0.
- All outputs are registered. No combinational input-to-output paths.
- State IDLE:
  - start_i -> PRESET next cycle.
  - busy_o=1, done_o=0, error_o=0, fpga_rst_o=1, fpga_clk_en_o=0.
- State PRESET:
  - pReset_o=1 for exactly PRESET_CYC cycles, then 0.
  - Then -> LOAD.
- State LOAD:
  - word_ready_o=1.
  - Handshake when word_valid_i && word_ready_o: latch word_i into shift register, word_ready_o=0 next cycle, -> SHIFT.
  - Wait counter increments each LOAD cycle and clears on handshake.
  - Reaching TIMEOUT -> ERROR.
- State SHIFT, per bit (2*HALF cycles):
  - Cycle 0 of the low phase: data_o <= shreg MSB, progclk_o=0 for HALF cycles.
  - Then progclk_o=1 for HALF cycles.
  - tail_o is sampled in the cycle progclk_o goes high.
  - On the falling transition: shreg shifts left and bit count increments.
- After DATA_W bits: -> LOAD.
- When bit count reaches CHAIN_LEN: -> FINISH. Remaining bits of the final word are discarded. No further word is requested.
- State FINISH:
  - progclk_o=0, data_o=0.
  - Wait one progclk period, then fpga_rst_o=0, fpga_clk_en_o=1, done_o=1, busy_o=0.
  - -> DONE.
- State DONE:
  - Holds outputs.
  - start_i restarts: clears done_o, fpga_rst_o=1, fpga_clk_en_o=0, -> PRESET.
- State ERROR:
  - error_o=1, busy_o=0, fpga_rst_o=1, fpga_clk_en_o=0, progclk_o=0.
  - start_i restarts as from DONE.
- start_i while busy_o=1 is ignored.
- abort_i has priority over start_i in the same cycle. Effect next cycle from any state:
  - -> IDLE.
  - progclk_o=0, pReset_o=0, word_ready_o=0.
  - fpga_rst_o=1, fpga_clk_en_o=0, busy_o=0, done_o=0, error_o=0.
  - Counters cleared. Any partially shifted word is lost.
- Async reset mid-operation behaves identically to abort, with reset values.
- Word count consumed = ceil(CHAIN_LEN/DATA_W).
- Total progclk rising edges = CHAIN_LEN exactly.

Test Plan:
- Basic program (params CHAIN_LEN=40, DATA_W=32, HALF=2, PRESET_CYC=4), stimulus: start, words 0xA5A5_0001 and 0xFF00_0000 always valid.
  - pReset_o high 4 cycles.
  - 2 handshakes.
  - 40 progclk rises.
  - data_o sequence = 32 bits of word0 MSB-first, then 8 ones.
  - fpga_rst_o falls and done_o=1.
- Backpressure: word_valid_i low 10 cycles before word 2 -> word_ready_o stays high, progclk_o stays 0 during stall, and the bit stream is identical to the basic case.
- Underrun, TIMEOUT=16: no second word -> error_o=1 after 16 LOAD cycles, fpga_rst_o=1, fpga_clk_en_o=0, busy_o=0.
- Abort at the 20th progclk rise -> next cycle IDLE, all flags 0, fpga_rst_o=1. A subsequent start reprograms correctly from bit 0.
- start_i during SHIFT is ignored. start_i and abort_i asserted together -> IDLE. start_i from DONE -> done_o cleared, new PRESET.
- Tail loopback: ccff_tail_i tied to data_o delayed by 40 progclk edges -> tail_o reproduces word0 MSB-first in the second pass.
